// File: rtl/mac_queue_pkg.sv
// Shared sizing constants and occupancy helper for the operand queue
// and the downstream ready-mask decoder.
package mac_queue_pkg;

    localparam int unsigned BufferWidth       = 2;
    localparam int unsigned BufferSize        = 4;
    localparam int unsigned PseudoBufferWidth = BufferWidth + 1;
    localparam int unsigned DataWidth         = 16;

    // Occupancy from the wrap bit and both pointers; the extra MSB absorbs wrap.
    function automatic logic [PseudoBufferWidth-1:0] calc_count(
        input logic                   round,
        input logic [BufferWidth-1:0] tp,
        input logic [BufferWidth-1:0] hp
    );
        return PseudoBufferWidth'({round, tp}) - PseudoBufferWidth'({1'b0, hp});
    endfunction

endpackage

// File: rtl/queue_ptr.sv
// Circular pointer with increment enable and a one-cycle wrap pulse
// asserted on the increment that rolls over from BufferSize-1 to 0.
module queue_ptr
    import mac_queue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [BufferWidth-1:0] ptr,
    output logic                   wrap_c
);

    logic [BufferWidth-1:0] ptr_q;
    logic [BufferWidth-1:0] ptr_d;

    // Next pointer and wrap detect; modulo comes free from the power-of-two size.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_c = 1'b0;
        if (inc) begin
            ptr_d  = ptr_q + BufferWidth'(1);
            wrap_c = (ptr_q == BufferWidth'(BufferSize - 1));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/operand_queue.sv
// Four-entry circular operand FIFO feeding the MAC datapath. Exports
// TP/HP/Round so the ready-mask decoder can build a slot occupancy mask.
// Optional sticky push-while-full flag: define OPERAND_QUEUE_OVERFLOW_EN.
module operand_queue
    import mac_queue_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [DataWidth-1:0]         push_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [DataWidth-1:0]         pop_data,
    output logic [BufferWidth-1:0]       TP,
    output logic [BufferWidth-1:0]       HP,
    output logic                         Round,
    output logic [PseudoBufferWidth-1:0] count
`ifdef OPERAND_QUEUE_OVERFLOW_EN
    ,
    output logic                         overflow
`endif
);

    logic [DataWidth-1:0]   mem_q [BufferSize];
    logic [DataWidth-1:0]   mem_d [BufferSize];
    logic                   round_q;
    logic                   round_d;
    logic [BufferWidth-1:0] tp;
    logic [BufferWidth-1:0] hp;
    logic                   tail_wrap;
    logic                   head_wrap;
    logic                   full;
    logic                   empty;
    logic                   push_fire;
    logic                   pop_fire;

    // Status is a pure function of registered state; no path from the handshake inputs.
    assign empty     = (tp == hp) && !round_q;
    assign full      = (tp == hp) &&  round_q;
    assign push_fire = push_valid && !full;
    assign pop_fire  = pop_ready  && !empty;

    queue_ptr u_tail_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (push_fire),
        .ptr    (tp),
        .wrap_c (tail_wrap)
    );

    queue_ptr u_head_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (pop_fire),
        .ptr    (hp),
        .wrap_c (head_wrap)
    );

    // Round flips when exactly one pointer wraps; array write at the tail slot.
    always_comb begin
        round_d = round_q ^ (tail_wrap ^ head_wrap);
        mem_d   = mem_q;
        if (push_fire) begin
            mem_d[tp] = push_data;
        end
    end

    // Wrap bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= 1'b0;
        end else begin
            round_q <= round_d;
        end
    end

    // Operand storage; contents are left alone on reset since pointers discard them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef OPERAND_QUEUE_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Sticky flag for a push offered while full; never affects queue state.
    always_comb begin
        overflow_d = overflow_q | (push_valid && full);
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign pop_data   = mem_q[hp];
    assign TP         = tp;
    assign HP         = hp;
    assign Round      = round_q;
    assign count      = calc_count(round_q, tp, hp);

endmodule

// File: tb/tb_operand_queue.sv
// Scoreboard bench for operand_queue: driver keeps push/pop totals since
// reset as the reference model; a monitor checks popped data in order.
module tb_operand_queue;
    import mac_queue_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         push_valid = 1'b0;
    logic                         push_ready;
    logic [DataWidth-1:0]         push_data = '0;
    logic                         pop_valid;
    logic                         pop_ready = 1'b0;
    logic [DataWidth-1:0]         pop_data;
    logic [BufferWidth-1:0]       TP;
    logic [BufferWidth-1:0]       HP;
    logic                         Round;
    logic [PseudoBufferWidth-1:0] count;
`ifdef OPERAND_QUEUE_OVERFLOW_EN
    logic                         overflow;
    logic                         ovf_m = 1'b0;
`endif

    operand_queue dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .TP         (TP),
        .HP         (HP),
        .Round      (Round),
        .count      (count)
`ifdef OPERAND_QUEUE_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int p_cnt    = 0;   // pushes accepted since reset
    int q_cnt    = 0;   // pops accepted since reset
    bit done     = 1'b0;
    logic [DataWidth-1:0] sb [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected status from totals: slot = total mod size, wrap parity = lap difference.
    task automatic check_state();
        int occ;
        occ = p_cnt - q_cnt;
        check("TP",         int'(TP),         p_cnt % BufferSize);
        check("HP",         int'(HP),         q_cnt % BufferSize);
        check("Round",      int'(Round),      ((p_cnt / BufferSize) - (q_cnt / BufferSize)) % 2);
        check("count",      int'(count),      occ);
        check("push_ready", int'(push_ready), (occ < BufferSize) ? 1 : 0);
        check("pop_valid",  int'(pop_valid),  (occ > 0) ? 1 : 0);
`ifdef OPERAND_QUEUE_OVERFLOW_EN
        check("overflow",   int'(overflow),   int'(ovf_m));
`endif
    endtask

    // One cycle: check current state, drive inputs, advance the model to the next edge.
    task automatic step(input logic pv, input logic [DataWidth-1:0] pd,
                        input logic pr, input logic r);
        int occ;
        check_state();
        occ        = p_cnt - q_cnt;
        rst        = r;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = r ? 1'b0 : pr;
        if (r) begin
            p_cnt = 0;
            q_cnt = 0;
            sb.delete();
`ifdef OPERAND_QUEUE_OVERFLOW_EN
            ovf_m = 1'b0;
`endif
        end else begin
`ifdef OPERAND_QUEUE_OVERFLOW_EN
            if (pv && occ == BufferSize) ovf_m = 1'b1;
`endif
            if (pv && occ < BufferSize) begin
                sb.push_back(pd);
                p_cnt++;
            end
            if (pr && occ > 0) q_cnt++;
        end
        @(negedge clk);
    endtask

    // Monitor: head data must match scoreboard front whenever valid; pop on fire.
    initial begin
        logic [DataWidth-1:0] exp;
        while (!done) begin
            @(negedge clk);
            #2;
            if (!rst && pop_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp = sb[0];
                    check("pop_data", int'(pop_data), int'(exp));
                    if (pop_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Reset, then fill with 0x0011..0x0044 and hold.
        step(0, 16'h0, 0, 1);
        step(0, 16'h0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, DataWidth'(i * 16'h0011), 0, 0);
        step(0, 16'h0, 0, 0);
        // Drain in order.
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
        step(0, 16'h0, 0, 0);
        // One preload then continuous push+pop.
        step(1, 16'hAAAA, 0, 0);
        for (int i = 0; i < 10; i++) step(1, DataWidth'($urandom), 1, 0);
        step(0, 16'h0, 1, 0);
        // Full with push and pop offered: pop fires, push waits a cycle.
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, DataWidth'(16'h0100 + i), 0, 0);
        step(1, 16'h0DEF, 1, 0);
        step(1, 16'h0DEF, 0, 0);
        step(0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
        // Reach count=3, TP=1, Round=1, then reset; next push lands in slot 0.
        for (int i = 0; i < 4; i++) step(1, DataWidth'(16'h0200 + i), 0, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        step(1, 16'h0204, 0, 0);
        step(0, 16'h0, 0, 1);
        step(1, 16'h5555, 0, 0);
        step(0, 16'h0, 1, 0);
        // Empty push becomes visible one cycle later.
        step(1, 16'hBEEF, 0, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 0, 0);
        // Randomized traffic with alternating fill/drain bias and rare resets.
        for (int i = 0; i < 300; i++) begin
            bit fill;
            fill = ((i / 40) % 2) == 0;
            step(($urandom_range(99) < (fill ? 80 : 35)),
                 DataWidth'($urandom),
                 ($urandom_range(99) < (fill ? 35 : 80)),
                 ($urandom_range(99) < 2));
        end
        step(0, 16'h0, 0, 0);
        done = 1'b1;
        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_queue.md
# operand_queue

Four-entry circular operand buffer that feeds the MAC datapath. It accepts operands over a valid/ready push port and stores them in a register array. It returns them in FIFO order over a valid/ready pop port. It exports its tail pointer, head pointer and wrap (Round) bit to the downstream ready-mask decoder, which turns them into a per-slot occupancy mask.

## Interface
- BufferWidth, 2: pointer width; log2(BufferSize)
- BufferSize, 4: number of entries
- PseudoBufferWidth, 3: width of `count`; BufferWidth+1
- DataWidth, 16: operand width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  producer offers `push_data`
- push_ready  out  1  queue can accept; equals !full
- push_data  in  DataWidth  operand to enqueue
- pop_valid  out  1  head entry valid; equals !empty
- pop_ready  in  1  MAC consumes head entry
- pop_data  out  DataWidth  entry at HP; combinational read of registered array
- TP  out  BufferWidth  tail pointer, next write slot
- HP  out  BufferWidth  head pointer, next read slot
- Round  out  1  tail has wrapped once more than head
- count  out  PseudoBufferWidth  occupancy, 0..BufferSize
- overflow  out  1  sticky push-while-full flag; present only with the macro below

## Operation
- push fires when push_valid && push_ready. Effects: write mem[TP] <= push_data; TP <= TP+1 modulo BufferSize.
- pop fires when pop_valid && pop_ready. Effect: HP <= HP+1 modulo BufferSize.
- Round behaviour:
  - Round toggles when TP wraps from BufferSize-1 to 0.
  - Round toggles when HP wraps from BufferSize-1 to 0.
  - If both wrap in the same cycle, Round is unchanged.
- empty = (TP==HP) && !Round; full = (TP==HP) && Round.
- count = {Round,TP} - {1'b0,HP}, truncated to PseudoBufferWidth bits. It is registered-consistent with TP/HP/Round; no separate counter.
- Simultaneous push and pop:
  - Legal whenever both fire.
  - Both pointers advance; count is unchanged.
  - The written slot never equals the read slot unless the queue is empty, and empty implies pop does not fire.
- Full: push_ready=0. A pop in that cycle frees a slot, which is visible only from the next cycle. There is no same-cycle push-through.
- Empty: pop_valid=0. A pushed entry appears on pop_data one cycle after the push fires.
- pop_data is don't-care when pop_valid=0. The bench must not check it.
- Reset mid-operation: TP, HP and Round clear, so all contents are logically discarded. The array is not cleared.

## Timing
- Reset values: TP=0, HP=0, Round=0, count=0, push_ready=1, pop_valid=0, overflow=0.
- push to pop_valid latency: 1 cycle.
- pop to the next head on pop_data: 1 cycle.
- push_ready and pop_valid depend only on state. There is no combinational path from push_valid or pop_ready.
- TP, HP and Round are registered outputs. The downstream decoder sees the post-edge state in the same cycle.

## Configuration
- OPERAND_QUEUE_OVERFLOW_EN defined:
  - `overflow` port exists.
  - It sets on any cycle with push_valid && full.
  - It holds until rst.
  - State is unaffected.
- Undefined: no `overflow` port. Push while full is silently held off by push_ready=0.

## Structure
- Package mac_queue_pkg: BufferWidth, BufferSize, PseudoBufferWidth, DataWidth constants, plus a helper function computing count from {Round,TP,HP}. The ready-mask decoder imports the same package.
- Sub-module queue_ptr: BufferWidth-bit pointer with increment enable and a wrap pulse output. It is instantiated twice (tail, head). The top level combines the two wrap pulses into Round.

## Test plan
- Reset, then 4 pushes of 0x0011..0x0044 with no pops -> TP=0, HP=0, Round=1, count=4, push_ready=0, pop_valid=1, pop_data=0x0011.
- From full, 4 pops -> pop_data sequence 0x0011, 0x0022, 0x0033, 0x0044; final TP=HP=0, Round=0, pop_valid=0.
- Continuous push+pop every cycle for 10 cycles after one preload -> count stays 1 and data stays in order. Round toggles only on cycles where exactly one pointer wraps.
- Full with push_valid=1 and pop_ready=1 -> the pop fires; the push is accepted on the next cycle. With OPERAND_QUEUE_OVERFLOW_EN, overflow=1 and stays 1.
- rst asserted with count=3 and TP=1, Round=1 -> next cycle all outputs equal their reset values; a subsequent push lands in slot 0.
- Empty with push_valid=1, push_data=0xBEEF -> pop_valid=0 that cycle; pop_valid=1 and pop_data=0xBEEF the next cycle.
